noc_port_arbiter: RTL and testbench

//  Output-port resource arbiter for one router output. Shares the output's virtual channels (VCs) and physical link among

---
 rtl/noc_config_pkg.sv | 11 +
 rtl/noc_round_robin_arbiter.sv | 62 ++++++
 rtl/noc_port_arbiter.sv | 58 +++++
 tb/tb_noc_port_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/noc_config_pkg.sv
// Router configuration shared by the NoC output-port blocks.
package noc_config_pkg;

  typedef struct packed {
    logic [7:0] virtual_channels;
  } noc_config;

  localparam noc_config NOC_DEFAULT_CONFIG = '{virtual_channels: 8'd2};
  localparam int CHANNELS = int'(NOC_DEFAULT_CONFIG.virtual_channels);

endpackage

// File: rtl/noc_round_robin_arbiter.sv
// Lock-until-free round-robin arbiter with same-edge handover to the next requester.
module noc_round_robin_arbiter #(
  parameter int REQUESTS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [REQUESTS-1:0] i_request,
  output logic [REQUESTS-1:0] o_grant,
  input  logic [REQUESTS-1:0] i_free
);

  localparam int PTR_W = $clog2(REQUESTS);

  logic [REQUESTS-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic                found;
  logic                rearbitrate;
  int                  win;
  int                  idx;

  // A free only counts when it names the current owner.
  assign rearbitrate = (grant_q == '0) || ((grant_q & i_free) != '0);

  always_comb begin
    found = 1'b0;
    win   = 0;
    idx   = 0;
    for (int k = 0; k < REQUESTS; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= REQUESTS) idx = idx - REQUESTS;
      if (!found && i_request[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (rearbitrate) begin
      grant_d = '0;
      if (found) begin
        grant_d[win] = 1'b1;
        ptr_d        = (win == REQUESTS - 1) ? '0 : PTR_W'(win + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_grant = grant_q;

endmodule

// File: rtl/noc_port_arbiter.sv
// Output-port arbiter: per-VC round-robin ownership plus a round-robin lock on the physical link.
module noc_port_arbiter #(
  parameter noc_config_pkg::noc_config CONFIG = noc_config_pkg::NOC_DEFAULT_CONFIG,
  parameter int ENTRIES = 5,
  localparam int CHANNELS = int'(CONFIG.virtual_channels)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ENTRIES*CHANNELS-1:0]   i_vc_request,
  output logic [ENTRIES*CHANNELS-1:0]   o_vc_grant,
  input  logic [ENTRIES*CHANNELS-1:0]   i_vc_free,
  input  logic [ENTRIES*CHANNELS-1:0]   i_port_request,
  output logic [ENTRIES*CHANNELS-1:0]   o_port_grant,
  input  logic [ENTRIES*CHANNELS-1:0]   i_port_free
);

  localparam int SLOTS = ENTRIES * CHANNELS;

  logic [SLOTS-1:0] port_eligible;
  logic [SLOTS-1:0] port_release;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_vc
    logic [ENTRIES-1:0] req_col, free_col, gnt_col;

    for (genvar e = 0; e < ENTRIES; e++) begin : g_entry
      assign req_col[e]                = i_vc_request[e*CHANNELS+c];
      assign free_col[e]               = i_vc_free[e*CHANNELS+c];
      assign o_vc_grant[e*CHANNELS+c]  = gnt_col[e];
    end

    noc_round_robin_arbiter #(.REQUESTS(ENTRIES)) u_vc_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_request (req_col),
      .o_grant   (gnt_col),
      .i_free    (free_col)
    );

    a_vc_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_col));
  end

  // A VC being freed this edge must not win the port, or the port would outlive its VC.
  assign port_eligible = i_port_request & o_vc_grant & ~i_vc_free;
  assign port_release  = i_port_free | (i_vc_free & o_vc_grant);

  noc_round_robin_arbiter #(.REQUESTS(SLOTS)) u_port_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_request (port_eligible),
    .o_grant   (o_port_grant),
    .i_free    (port_release)
  );

  a_port_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(o_port_grant));
  a_port_owns_vc: assert property (@(posedge clk) disable iff (!rst_n)
                                   ((o_port_grant & ~o_vc_grant) == '0));

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Directed bench for noc_port_arbiter with ENTRIES=5, CHANNELS=2 (bit index e*2+c).
module tb_noc_port_arbiter;

  localparam int W = 10;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] vc_req, vc_gnt, vc_free, port_req, port_gnt, port_free;

  int n_checks;
  int n_fail;

  noc_port_arbiter #(.ENTRIES(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_vc_request   (vc_req),
    .o_vc_grant     (vc_gnt),
    .i_vc_free      (vc_free),
    .i_port_request (port_req),
    .o_port_grant   (port_gnt),
    .i_port_free    (port_free)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    vc_req = '0; vc_free = '0; port_req = '0; port_free = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    vc_req = '1; port_req = '1; vc_free = '0; port_free = '0;
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if (vc_gnt !== 10'b0) begin n_fail++; $display("FAIL reset_vc: got %b want %b", vc_gnt, 10'b0); end
    n_checks++;
    if (port_gnt !== 10'b0) begin n_fail++; $display("FAIL reset_port: got %b want %b", port_gnt, 10'b0); end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (vc_gnt !== 10'b00000_00011) begin n_fail++; $display("FAIL release_vc: got %b want %b", vc_gnt, 10'b11); end
    tick();
    n_checks++;
    if (port_gnt !== 10'b00000_00001) begin n_fail++; $display("FAIL release_port: got %b want %b", port_gnt, 10'b1); end
    n_checks++;
    if (vc_gnt !== 10'b00000_00011) begin n_fail++; $display("FAIL release_vc_held: got %b want %b", vc_gnt, 10'b11); end
  endtask

  task automatic test_fairness();
    logic [W-1:0] exp;
    apply_reset();
    vc_req = 10'b01010_10101;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp = '0;
      exp[(i % 5) * 2] = 1'b1;
      n_checks++;
      if (vc_gnt !== exp) begin n_fail++; $display("FAIL fairness_%0d: got %b want %b", i, vc_gnt, exp); end
      vc_free = exp;
    end
    vc_free = '0;
    vc_req = '0;
  endtask

  task automatic test_hold();
    apply_reset();
    vc_req = 10'b00001_00000;
    tick();
    vc_req = 10'b10000_00000;
    for (int i = 0; i < 10; i++) begin
      vc_free = (i == 4) ? 10'b00100_00000 : 10'b0;
      tick();
      n_checks++;
      if (vc_gnt !== 10'b00001_00000) begin n_fail++; $display("FAIL hold_%0d: got %b want %b", i, vc_gnt, 10'b00001_00000); end
    end
    vc_free = 10'b00001_00000;
    tick();
    vc_free = '0;
    n_checks++;
    if (vc_gnt !== 10'b10000_00000) begin n_fail++; $display("FAIL hold_handover: got %b want %b", vc_gnt, 10'b10000_00000); end
    vc_req = '0;
  endtask

  task automatic test_masking();
    apply_reset();
    vc_req = 10'b00000_00001;
    port_req = 10'b00000_00100;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (port_gnt !== 10'b0) begin n_fail++; $display("FAIL mask_%0d: got %b want %b", i, port_gnt, 10'b0); end
    end
    n_checks++;
    if (vc_gnt !== 10'b00000_00001) begin n_fail++; $display("FAIL mask_vc: got %b want %b", vc_gnt, 10'b1); end
    port_req = '0;
    vc_req = '0;
  endtask

  task automatic test_handover();
    apply_reset();
    vc_req = 10'b00100_00001;
    port_req = 10'b00100_00001;
    tick();
    n_checks++;
    if (vc_gnt !== 10'b00100_00001) begin n_fail++; $display("FAIL handover_vc: got %b want %b", vc_gnt, 10'b00100_00001); end
    tick();
    n_checks++;
    if (port_gnt !== 10'b00000_00001) begin n_fail++; $display("FAIL handover_first: got %b want %b", port_gnt, 10'b1); end
    tick();
    n_checks++;
    if (port_gnt !== 10'b00000_00001) begin n_fail++; $display("FAIL handover_held: got %b want %b", port_gnt, 10'b1); end
    port_free = 10'b00000_00001;
    tick();
    port_free = '0;
    n_checks++;
    if (port_gnt !== 10'b00100_00000) begin n_fail++; $display("FAIL handover_next: got %b want %b", port_gnt, 10'b00100_00000); end
    n_checks++;
    if (vc_gnt !== 10'b00100_00001) begin n_fail++; $display("FAIL handover_vc_kept: got %b want %b", vc_gnt, 10'b00100_00001); end
  endtask

  task automatic test_forced_release();
    port_req = 10'b00100_00000;
    tick();
    vc_req = 10'b00000_00001;
    port_req = '0;
    vc_free = 10'b00100_00000;
    tick();
    vc_free = '0;
    n_checks++;
    if (port_gnt !== 10'b0) begin n_fail++; $display("FAIL forced_port: got %b want %b", port_gnt, 10'b0); end
    n_checks++;
    if (vc_gnt !== 10'b00000_00001) begin n_fail++; $display("FAIL forced_vc: got %b want %b", vc_gnt, 10'b1); end
    port_req = 10'b00000_00001;
    tick();
    n_checks++;
    if (port_gnt !== 10'b00000_00001) begin n_fail++; $display("FAIL regrant_port: got %b want %b", port_gnt, 10'b1); end
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (vc_gnt !== 10'b0) begin n_fail++; $display("FAIL async_vc: got %b want %b", vc_gnt, 10'b0); end
    n_checks++;
    if (port_gnt !== 10'b0) begin n_fail++; $display("FAIL async_port: got %b want %b", port_gnt, 10'b0); end
    vc_req = '0;
    port_req = '0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    vc_req = '0; vc_free = '0; port_req = '0; port_free = '0;
    test_reset();
    test_fairness();
    test_hold();
    test_masking();
    test_handover();
    test_forced_release();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
